// File: rtl/nonconsec_seq_gen.sv
// nonconsec_seq_gen: drives one a_o pulse, NUM_B gapped b_o pulses, then c_o.
// Stimulus source for the A/B/C non-consecutive repetition protocol.
`default_nettype none

module nonconsec_seq_gen #(
  parameter int          NUM_B = 3,
  parameter int          GAP_W = 4,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [GAP_W-1:0] gap_cfg,
  input  logic             rand_en,
  input  logic [GAP_W-1:0] c_hold,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             busy,
  output logic             done,
  output logic [3:0]       b_cnt
);

  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [3:0]       LAST_B   = 4'(NUM_B - 1);
  localparam logic [GAP_W-1:0] ONE      = {{(GAP_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_GAP  = 3'd2,
    S_B    = 3'd3,
    S_C    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [3:0]       b_cnt_q, b_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] hold_q, hold_d;
  logic             rand_q, rand_d;
  logic [GAP_W-1:0] gap_val;
  logic [15:0]      lfsr_step;

  always_comb begin
    gap_val   = rand_q ? (lfsr_q[GAP_W-1:0] & gap_q) : gap_q;
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_cnt_d = b_cnt_q;
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    rand_d  = rand_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          gap_d   = gap_cfg;
          hold_d  = c_hold;
          rand_d  = rand_en;
          state_d = S_A;
        end
      end
      S_A: begin
        lfsr_d = lfsr_step;
        if (gap_val != '0) begin
          cnt_d   = gap_val - ONE;
          state_d = S_GAP;
        end else begin
          state_d = S_B;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_B;
        else             cnt_d   = cnt_q - ONE;
      end
      S_B: begin
        // b_cnt shows pulses issued before this one; it steps on leaving B.
        if (b_cnt_q == LAST_B) begin
          if (hold_q != '0) begin
            b_cnt_d = b_cnt_q + 4'd1;
            cnt_d   = hold_q - ONE;
            state_d = S_C;
          end else begin
            b_cnt_d = 4'd0;
            state_d = S_DONE;
          end
        end else begin
          b_cnt_d = b_cnt_q + 4'd1;
          lfsr_d  = lfsr_step;
          if (gap_val != '0) begin
            cnt_d   = gap_val - ONE;
            state_d = S_GAP;
          end else begin
            state_d = S_B;
          end
        end
      end
      S_C: begin
        if (cnt_q == '0) begin
          b_cnt_d = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DONE: begin
        b_cnt_d = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      b_cnt_q <= 4'd0;
      lfsr_q  <= SEED_EFF;
      gap_q   <= '0;
      hold_q  <= '0;
      rand_q  <= 1'b0;
      a_o     <= 1'b0;
      b_o     <= 1'b0;
      c_o     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_cnt_q <= b_cnt_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      rand_q  <= rand_d;
      a_o     <= (state_d == S_A);
      b_o     <= (state_d == S_B);
      c_o     <= ((state_d == S_B) && (b_cnt_d == LAST_B)) || (state_d == S_C);
      busy    <= (state_d == S_A) || (state_d == S_GAP) || (state_d == S_B) ||
                 (state_d == S_C);
      done    <= (state_d == S_DONE);
    end
  end

  assign b_cnt = b_cnt_q;

endmodule

`default_nettype wire

// File: doc/nonconsec_seq_gen.md
# nonconsec_seq_gen

Synthesizable stimulus source for the non-consecutive repetition protocol: on a start request it drives one `a_o` pulse, then `NUM_B` single-cycle `b_o` pulses separated by fixed or pseudo-random gaps, then asserts `c_o`. Every sequence it produces satisfies `(a_o ##1 b_o[=NUM_B]) |-> c_o`. It is the transmitter side of the A/B/C sequence and feeds the assertion-based monitors in our benches and FPGA self-test harnesses.

## Interface
- `NUM_B`, 3, number of `b_o` pulses per sequence (1..15).
- `GAP_W`, 4, width of gap and hold fields.
- `SEED`, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  sequence request; sampled only in IDLE.
- `gap_cfg`  in  GAP_W  fixed gap (rand_en=0) or gap mask (rand_en=1).
- `rand_en`  in  1  selects LFSR-derived gaps; latched at start.
- `c_hold`  in  GAP_W  extra cycles `c_o` stays high after the last `b_o`; latched at start.
- `a_o`  out  1  trigger pulse.
- `b_o`  out  1  repetition pulse.
- `c_o`  out  1  consequent.
- `busy`  out  1  high from the A cycle through the last C cycle.
- `done`  out  1  one-cycle pulse after the last C cycle.
- `b_cnt`  out  4  number of `b_o` pulses issued in the current sequence.

## Operation
- FSM states are IDLE, A, GAP, B, C, DONE.
- IDLE:
  - `start`=1 latches `gap_cfg`, `rand_en` and `c_hold`, then moves to A.
  - `start` in any other state is ignored and is not queued.
- A: `a_o`=1 for one cycle. Compute the first gap G. Go to GAP if G>0, else to B.
- GAP: `b_o`=0 for G cycles, driven by a down-counter. Then go to B.
- B:
  - `b_o`=1 for one cycle and `b_cnt` increments.
  - If `b_cnt` (before increment) is `NUM_B`-1, this is the final pulse: `c_o`=1 in this same cycle, go to C if the latched hold > 0, else go to DONE.
  - Otherwise compute the next gap and go to GAP, or back to B if the gap is 0.
- C: `c_o`=1 and `b_o`=0 for the latched `c_hold` cycles, then go to DONE.
- DONE:
  - `done`=1 for one cycle and all other outputs are 0.
  - `b_cnt` clears to 0. Return to IDLE.
- Gap computation:
  - rand_en=0: G = latched `gap_cfg`.
  - rand_en=1: G = lfsr[GAP_W-1:0] & latched `gap_cfg`, so a mask of 0 yields back-to-back B pulses.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, right-shifting with tap mask 16'hB400. It advances exactly once per gap computation and never in other cycles.
- `b_o` never goes high outside state B. `c_o` is never high before the final B pulse.

## Timing
- All outputs are registered from the state, so no combinational path exists from inputs to outputs.
- Let `start` be sampled high at edge T:
  - `a_o` is high in cycle T+1.
  - The first `b_o` is high in cycle T+2+G1.
  - Pulse k is high in cycle T+1+k+sum(G1..Gk).
- `c_o` is high from the final B cycle through hold more cycles, i.e. hold+1 cycles total.
- `done` fires in the cycle after the last `c_o` cycle. IDLE is re-entered one cycle later, so the earliest next `a_o` comes 2 cycles after `done`.
- Reset values, forced immediately by the asynchronous `rst`=0:
  - state = IDLE.
  - All outputs = 0.
  - `b_cnt` = 0.
  - LFSR = `SEED`.
  - Latched config = 0.
- Reset asserted mid-sequence aborts it. No `done` is produced. After release, the block waits for a new `start`.
- `start` held high continuously produces back-to-back sequences with the 2-cycle IDLE/DONE spacing and no overlap.

## Test plan
- Back-to-back B pulses. Stimulus: `gap_cfg`=0, `rand_en`=0, `c_hold`=0, `start` at edge T. Required response:
  - `a_o` at T+1.
  - `b_o` at T+2, T+3, T+4.
  - `c_o` only at T+4.
  - `done` at T+5.
- Fixed gaps with hold. Stimulus: `gap_cfg`=2, `c_hold`=3. Required response:
  - `a_o` at T+1.
  - `b_o` at T+4, T+7, T+10.
  - `c_o` from T+10 through T+13.
  - `done` at T+14.
  - `busy` high from T+1 through T+13.
- Ignored start: pulse `start` during GAP. Required response: `b_cnt` still ends at 3, no second `a_o` appears before `done`, and no extra sequence follows.
- Random mode:
  - `rand_en`=1 with `gap_cfg`=4'hF over 200 sequences. Required response: every gap ≤ 15, and a bound SVA `(a_o ##1 b_o[=3]) |-> c_o` passes with no failures.
  - `rand_en`=1 with `gap_cfg`=0. Required response: timing identical to the back-to-back scenario.
- Reset mid-sequence: assert `rst`=0 after the second `b_o`. Required response:
  - All outputs are 0 within the same time step.
  - After release, no activity until a new `start`.
  - The next sequence uses an LFSR restarted from `SEED`.
